// File: rtl/rr_arb3_word_sel_pkg.sv
// Shared encodings for the 3-source round-robin word selector.
// Select codes double as source indices; pointer states record the last winner.
package rr_arb3_word_sel_pkg;

    localparam logic [1:0] SEL_SRC0 = 2'b00;
    localparam logic [1:0] SEL_SRC1 = 2'b01;
    localparam logic [1:0] SEL_SRC2 = 2'b10;

    typedef enum logic [1:0] {
        LAST0 = 2'd0,
        LAST1 = 2'd1,
        LAST2 = 2'd2
    } ptr_e;

endpackage

// File: rtl/bit32_3to1mux.sv
// Purpose: 32-bit 3:1 word mux driven by the arbiter select.
// Latency: combinational.
// Backpressure: none; select code 2'b11 is never driven and yields zero.
module bit32_3to1mux
    import rr_arb3_word_sel_pkg::*;
(
    input  logic [1:0]  sel,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [31:0] in3,
    output logic [31:0] out
);

    always_comb begin
        out = '0;
        case (sel)
            SEL_SRC0: out = in1;
            SEL_SRC1: out = in2;
            SEL_SRC2: out = in3;
            default:  out = '0;
        endcase
    end

endmodule

// File: rtl/rr_arb3_word_sel_cnt.sv
// Purpose: saturating per-source grant counter with synchronous clear.
// Latency: count visible 1 clk after the increment; clear wins over increment.
// Backpressure: none; holds at all-ones instead of wrapping.
module rr_arb3_word_sel_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/rr_arb3_word_sel.sv
// Purpose: round-robin arbitration of three word sources into a one-deep output register.
// Latency: accepted word appears on out_data 1 clk after its src_ready.
// Backpressure: grants only when the output register is empty or draining this cycle.
module rr_arb3_word_sel
    import rr_arb3_word_sel_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       src_valid,
    input  logic [31:0]      src0_data,
    input  logic [31:0]      src1_data,
    input  logic [31:0]      src2_data,
    output logic [2:0]       src_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic [1:0]       out_src,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1,
    output logic [CNT_W-1:0] grant_cnt2
);

    ptr_e        state_q;
    ptr_e        state_d;
    logic        load;
    logic [2:0]  req;
    logic [2:0]  grant;
    logic [1:0]  sel;
    logic [31:0] mux_dat;

    logic        out_valid_q;
    logic [31:0] out_data_q;
    logic [1:0]  out_src_q;

    logic [CNT_W-1:0] cnt [3];

    assign load = ~out_valid_q | out_ready;
    // rst_n gating keeps src_ready low for the whole reset window, not just after an edge.
    assign req  = src_valid & {3{load & rst_n}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LAST2;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        grant   = 3'b000;
        state_d = state_q;
        sel     = SEL_SRC0;
        case (state_q)
            LAST0: begin
                if      (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            LAST1: begin
                if      (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
            default: begin
                if      (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
        endcase

        if (grant[0]) begin
            state_d = LAST0;
            sel     = SEL_SRC0;
        end else if (grant[1]) begin
            state_d = LAST1;
            sel     = SEL_SRC1;
        end else if (grant[2]) begin
            state_d = LAST2;
            sel     = SEL_SRC2;
        end
    end

    assign src_ready = grant;

    bit32_3to1mux u_mux (
        .sel (sel),
        .in1 (src0_data),
        .in2 (src1_data),
        .in3 (src2_data),
        .out (mux_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= SEL_SRC0;
        end else if (|grant) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mux_dat;
            out_src_q   <= sel;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

    for (genvar i = 0; i < 3; i++) begin : g_cnt
        rr_arb3_word_sel_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (cnt_clr),
            .inc_i (grant[i]),
            .cnt_o (cnt[i])
        );
    end

    assign grant_cnt0 = cnt[0];
    assign grant_cnt1 = cnt[1];
    assign grant_cnt2 = cnt[2];

endmodule
